// File: rtl/period_band_detector.sv
// -----------------------------------------------------------------------------
// period_band_detector
//
// Averages windows of 2**AVG_LOG2 period measurements and classifies each
// window average into one of two frequency bands. A band is reported as
// locked only after CONFIRM consecutive windows agree. The result is cleared
// when no accepted sample has arrived for TIMEOUT clocks.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   period        measured period in clk counts (0 is treated as "no data")
//   period_valid  one-cycle strobe qualifying period
//   avg_period    average of the most recent complete window
//   avg_valid     one-cycle strobe, avg_period has just been updated
//   band          2'b00 none, 2'b01 band 0, 2'b10 band 1
//   locked        band is confirmed
//   lock_change   one-cycle pulse whenever {band, locked} changes
//   timeout_flag  one-cycle pulse when the input has gone silent
// -----------------------------------------------------------------------------
module period_band_detector #(
    parameter int unsigned AVG_LOG2 = 2,
    parameter logic [15:0] B0_MIN   = 16'd45000,
    parameter logic [15:0] B0_MAX   = 16'd55000,
    parameter logic [15:0] B1_MIN   = 16'd4500,
    parameter logic [15:0] B1_MAX   = 16'd5500,
    parameter int unsigned CONFIRM  = 3,
    parameter int unsigned TIMEOUT  = 200000,
    parameter int unsigned TO_W     = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] period,
    input  logic        period_valid,
    output logic [15:0] avg_period,
    output logic        avg_valid,
    output logic [1:0]  band,
    output logic        locked,
    output logic        lock_change,
    output logic        timeout_flag
);

    // Accumulator is wide enough for 2**AVG_LOG2 full-scale samples.
    localparam int unsigned     ACC_W   = 16 + AVG_LOG2;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]      CONF_N  = 4'(CONFIRM);

    localparam logic [1:0] CLS_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CAND   = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    // Map an average period onto a band code; band 0 wins when ranges overlap.
    function automatic logic [1:0] classify(input logic [15:0] avg);
        logic [1:0] cls;
        if ((avg >= B0_MIN) && (avg <= B0_MAX)) begin
            cls = 2'b01;
        end else if ((avg >= B1_MIN) && (avg <= B1_MAX)) begin
            cls = 2'b10;
        end else begin
            cls = CLS_NONE;
        end
        return cls;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                accept_s;
    logic [ACC_W-1:0]    sum_s;
    logic                last_samp_s;
    logic                to_hit_s;
    logic [1:0]          class_s;

    logic [ACC_W-1:0]    acc_r;
    logic [AVG_LOG2-1:0] samp_cnt_r;
    logic [15:0]         avg_period_r;
    logic                avg_valid_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic                timeout_flag_r;

    state_t              state_r;
    state_t              state_nx_s;
    logic [1:0]          cand_r;
    logic [1:0]          cand_nx_s;
    logic [3:0]          conf_r;
    logic [3:0]          conf_nx_s;
    logic [1:0]          band_r;
    logic [1:0]          band_nx_s;
    logic                locked_r;
    logic                locked_nx_s;
    logic                lock_change_r;

    // A zero period carries no information and is dropped entirely.
    assign accept_s    = period_valid && (period != 16'd0);
    assign sum_s       = acc_r + ACC_W'(period);
    assign last_samp_s = &samp_cnt_r;

    // An accepted sample on the would-be timeout cycle takes priority.
    assign to_hit_s    = !accept_s && (to_cnt_r == TO_LAST);

    assign class_s     = classify(avg_period_r);

    // ------------------------------------------------------------------
    // Window accumulator and average output
    // ------------------------------------------------------------------

    // Accumulate accepted samples; emit the truncated mean on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r        <= {ACC_W{1'b0}};
            samp_cnt_r   <= {AVG_LOG2{1'b0}};
            avg_period_r <= 16'd0;
            avg_valid_r  <= 1'b0;
        end else begin
            avg_valid_r <= 1'b0;
            if (accept_s) begin
                if (last_samp_s) begin
                    avg_period_r <= sum_s[AVG_LOG2 +: 16];
                    avg_valid_r  <= 1'b1;
                    acc_r        <= {ACC_W{1'b0}};
                    samp_cnt_r   <= {AVG_LOG2{1'b0}};
                end else begin
                    acc_r        <= sum_s;
                    samp_cnt_r   <= samp_cnt_r + AVG_LOG2'(1);
                end
            end else if (to_hit_s) begin
                // A silent input invalidates any partially filled window.
                acc_r      <= {ACC_W{1'b0}};
                samp_cnt_r <= {AVG_LOG2{1'b0}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Silence timeout
    // ------------------------------------------------------------------

    // Count clocks since the last accepted sample, saturating at TIMEOUT so
    // the flag fires only once per silent period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r       <= {TO_W{1'b0}};
            timeout_flag_r <= 1'b0;
        end else begin
            timeout_flag_r <= to_hit_s;
            if (accept_s) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (to_cnt_r != TO_MAX) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------

    // Next-state logic; only evaluated on a fresh window average, except
    // that a timeout forces everything back to IDLE.
    always_comb begin
        state_nx_s  = state_r;
        cand_nx_s   = cand_r;
        conf_nx_s   = conf_r;
        band_nx_s   = band_r;
        locked_nx_s = locked_r;

        if (to_hit_s) begin
            state_nx_s  = ST_IDLE;
            cand_nx_s   = CLS_NONE;
            conf_nx_s   = 4'd0;
            band_nx_s   = CLS_NONE;
            locked_nx_s = 1'b0;
        end else if (avg_valid_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (class_s != CLS_NONE) begin
                        cand_nx_s = class_s;
                        conf_nx_s = 4'd1;
                        if (CONF_N <= 4'd1) begin
                            // A single window is enough to lock.
                            state_nx_s  = ST_LOCKED;
                            band_nx_s   = class_s;
                            locked_nx_s = 1'b1;
                        end else begin
                            state_nx_s  = ST_CAND;
                        end
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end

                ST_CAND: begin
                    if (class_s == CLS_NONE) begin
                        state_nx_s = ST_IDLE;
                        cand_nx_s  = CLS_NONE;
                        conf_nx_s  = 4'd0;
                    end else if (class_s == cand_r) begin
                        conf_nx_s = conf_r + 4'd1;
                        if ((conf_r + 4'd1) >= CONF_N) begin
                            state_nx_s  = ST_LOCKED;
                            band_nx_s   = cand_r;
                            locked_nx_s = 1'b1;
                        end else begin
                            state_nx_s  = ST_CAND;
                        end
                    end else begin
                        // A different valid band restarts the confirmation.
                        state_nx_s = ST_CAND;
                        cand_nx_s  = class_s;
                        conf_nx_s  = 4'd1;
                    end
                end

                ST_LOCKED: begin
                    if (class_s == band_r) begin
                        state_nx_s = ST_LOCKED;
                    end else begin
                        // Lock is dropped on the very update that disagrees.
                        band_nx_s   = CLS_NONE;
                        locked_nx_s = 1'b0;
                        if (class_s == CLS_NONE) begin
                            state_nx_s = ST_IDLE;
                            cand_nx_s  = CLS_NONE;
                            conf_nx_s  = 4'd0;
                        end else begin
                            state_nx_s = ST_CAND;
                            cand_nx_s  = class_s;
                            conf_nx_s  = 4'd1;
                        end
                    end
                end

                default: begin
                    state_nx_s  = ST_IDLE;
                    cand_nx_s   = CLS_NONE;
                    conf_nx_s   = 4'd0;
                    band_nx_s   = CLS_NONE;
                    locked_nx_s = 1'b0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State and registered band outputs; lock_change flags any output edit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cand_r        <= CLS_NONE;
            conf_r        <= 4'd0;
            band_r        <= CLS_NONE;
            locked_r      <= 1'b0;
            lock_change_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cand_r        <= cand_nx_s;
            conf_r        <= conf_nx_s;
            band_r        <= band_nx_s;
            locked_r      <= locked_nx_s;
            lock_change_r <= ({band_nx_s, locked_nx_s} != {band_r, locked_r});
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign avg_period   = avg_period_r;
    assign avg_valid    = avg_valid_r;
    assign band         = band_r;
    assign locked       = locked_r;
    assign lock_change  = lock_change_r;
    assign timeout_flag = timeout_flag_r;

endmodule

// File: tb/tb_period_band_detector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for period_band_detector (TIMEOUT shortened to 100).
// Expected window averages, lock transitions and timeout cycles are queued
// when stimulus is driven and popped when the DUT reports them.
// -----------------------------------------------------------------------------
module tb_period_band_detector;

    logic        clk;
    logic        rst_n;
    logic [15:0] period;
    logic        period_valid;
    logic [15:0] avg_period;
    logic        avg_valid;
    logic [1:0]  band;
    logic        locked;
    logic        lock_change;
    logic        timeout_flag;

    int checks        = 0;
    int failures      = 0;
    int cyc           = 0;
    int last_samp_cyc = 0;

    logic [15:0] avg_q[$];
    logic [2:0]  lc_q[$];
    int          to_q[$];

    period_band_detector #(
        .TIMEOUT (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .period       (period),
        .period_valid (period_valid),
        .avg_period   (avg_period),
        .avg_valid    (avg_valid),
        .band         (band),
        .locked       (locked),
        .lock_change  (lock_change),
        .timeout_flag (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and score every DUT output event against the queues.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (avg_valid === 1'b1) begin
            if (avg_q.size() != 0) chk("avg_period", 32'(avg_period), 32'(avg_q.pop_front()));
            else                   chk("avg_valid_spurious", 32'(avg_valid), 32'd0);
        end
        if (lock_change === 1'b1) begin
            if (lc_q.size() != 0) chk("lock_change_state", 32'({band, locked}), 32'(lc_q.pop_front()));
            else                  chk("lock_change_spurious", 32'(lock_change), 32'd0);
        end
        if (timeout_flag === 1'b1) begin
            if (to_q.size() != 0) chk("timeout_cycle", 32'(cyc), 32'(to_q.pop_front()));
            else                  chk("timeout_spurious", 32'(timeout_flag), 32'd0);
        end
    endtask

    task automatic put(input logic [15:0] p);
        period       = p;
        period_valid = 1'b1;
        step();
        if (p != 16'd0) last_samp_cyc = cyc;
        period_valid = 1'b0;
        period       = 16'd0;
    endtask

    task automatic idle(input int n);
        period_valid = 1'b0;
        repeat (n) step();
    endtask

    // Four back-to-back samples, then check latency and the band update.
    task automatic window(input logic [15:0] s0, input logic [15:0] s1,
                          input logic [15:0] s2, input logic [15:0] s3,
                          input logic [1:0] eb, input logic el, input logic elc);
        logic [17:0] sum;
        sum = 18'(s0) + 18'(s1) + 18'(s2) + 18'(s3);
        avg_q.push_back(sum[17:2]);
        put(s0); put(s1); put(s2); put(s3);
        chk("avg_valid_latency", 32'(avg_valid), 32'd1);
        if (elc) lc_q.push_back({eb, el});
        idle(1);
        chk("avg_valid_one_cycle", 32'(avg_valid), 32'd0);
        chk("band", 32'(band), 32'(eb));
        chk("locked", 32'(locked), 32'(el));
        chk("lock_change", 32'(lock_change), 32'(elc));
    endtask

    initial begin
        rst_n        = 1'b0;
        period       = 16'd5000;
        period_valid = 1'b1;

        // Reset held with strobes active: nothing may leak through.
        repeat (5) begin
            step();
            chk("reset_outputs", 32'({avg_period, avg_valid, band, locked, lock_change, timeout_flag}), 32'd0);
        end
        rst_n        = 1'b1;
        period_valid = 1'b0;
        period       = 16'd0;
        idle(2);

        // Average and latency; one window cannot lock.
        window(16'd5000, 16'd5002, 16'd5004, 16'd5006, 2'b00, 1'b0, 1'b0);
        // Out-of-band window returns to IDLE.
        window(16'd60000, 16'd60000, 16'd60000, 16'd60000, 2'b00, 1'b0, 1'b0);

        // Lock band 1 after three windows, then lose it on an out-of-band window.
        window(16'd5000, 16'd5000, 16'd5000, 16'd5000, 2'b00, 1'b0, 1'b0);
        window(16'd5000, 16'd5000, 16'd5000, 16'd5000, 2'b00, 1'b0, 1'b0);
        window(16'd5000, 16'd5000, 16'd5000, 16'd5000, 2'b10, 1'b1, 1'b1);
        window(16'd60000, 16'd60000, 16'd60000, 16'd60000, 2'b00, 1'b0, 1'b1);

        // Candidate switch: band 0 never confirms, band 1 does.
        window(16'd50000, 16'd50000, 16'd50000, 16'd50000, 2'b00, 1'b0, 1'b0);
        window(16'd50000, 16'd50000, 16'd50000, 16'd50000, 2'b00, 1'b0, 1'b0);
        window(16'd5000, 16'd5000, 16'd5000, 16'd5000, 2'b00, 1'b0, 1'b0);
        window(16'd5000, 16'd5000, 16'd5000, 16'd5000, 2'b00, 1'b0, 1'b0);
        window(16'd5000, 16'd5000, 16'd5000, 16'd5000, 2'b10, 1'b1, 1'b1);

        // Zero periods are ignored; the window still averages to 5000.
        avg_q.push_back(16'd5000);
        put(16'd0); put(16'd4500); put(16'd0); put(16'd5500); put(16'd4500); put(16'd5500);
        chk("zero_skip_avg_valid", 32'(avg_valid), 32'd1);
        idle(1);
        chk("zero_skip_band", 32'(band), 32'd2);
        chk("zero_skip_locked", 32'(locked), 32'd1);
        chk("zero_skip_no_change", 32'(lock_change), 32'd0);

        // 4499 (truncated mean) is below band 1: lock dropped.
        window(16'd4499, 16'd4499, 16'd4499, 16'd4500, 2'b00, 1'b0, 1'b1);
        // Band 0 edges 55000 and 45000 both classify as band 0.
        window(16'd55000, 16'd55000, 16'd55000, 16'd55000, 2'b00, 1'b0, 1'b0);
        window(16'd45000, 16'd45000, 16'd45000, 16'd45000, 2'b00, 1'b0, 1'b0);
        window(16'd55000, 16'd55000, 16'd55000, 16'd55000, 2'b01, 1'b1, 1'b1);

        // Partial window, then silence: one timeout pulse 100 clocks later.
        put(16'd60000);
        put(16'd60000);
        to_q.push_back(last_samp_cyc + 100);
        lc_q.push_back(3'b000);
        idle(120);
        chk("timeout_band", 32'(band), 32'd0);
        chk("timeout_locked", 32'(locked), 32'd0);
        chk("timeout_seen", 32'(to_q.size()), 32'd0);
        chk("timeout_lock_change_seen", 32'(lc_q.size()), 32'd0);

        // A sample on the 100th clock suppresses the timeout and is accumulated
        // into a fresh window (the partial 60000 samples were discarded).
        put(16'd5000);
        idle(99);
        put(16'd5000);
        chk("timeout_suppressed", 32'(timeout_flag), 32'd0);
        idle(20);
        avg_q.push_back(16'd5000);
        put(16'd5000);
        put(16'd5000);
        chk("post_timeout_avg_valid", 32'(avg_valid), 32'd1);
        idle(1);
        chk("post_timeout_band", 32'(band), 32'd0);

        idle(5);
        chk("avg_queue_drained", 32'(avg_q.size()), 32'd0);
        chk("lc_queue_drained", 32'(lc_q.size()), 32'd0);
        chk("to_queue_drained", 32'(to_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
